// File: rtl/SB_SPRAM256KA.sv
// Behavioural model of the iCE40 UltraPlus 16K x 16 single-port RAM primitive.
// Registered read, nibble write mask; contents survive reset because the macro has none.
module SB_SPRAM256KA (
  input  logic [13:0] ADDRESS,
  input  logic [15:0] DATAIN,
  input  logic [3:0]  MASKWREN,
  input  logic        WREN,
  input  logic        CHIPSELECT,
  input  logic        CLOCK,
  input  logic        STANDBY,
  input  logic        SLEEP,
  input  logic        POWEROFF,
  output logic [15:0] DATAOUT
);

  logic [15:0] mem [0:16383];
  logic        active;

  // POWEROFF is active-low on the real macro: 1 keeps the array powered.
  assign active = CHIPSELECT && !STANDBY && !SLEEP && POWEROFF;

  always_ff @(posedge CLOCK) begin
    if (active) begin
      if (WREN) begin
        for (int i = 0; i < 4; i++) begin
          if (MASKWREN[i]) begin
            mem[ADDRESS][4*i +: 4] <= DATAIN[4*i +: 4];
          end
        end
      end else begin
        DATAOUT <= mem[ADDRESS];
      end
    end
  end

endmodule

// File: rtl/spram_led_sequencer.sv
// LED pattern player: host loads patterns into one SPRAM, then playback steps
// through entries 0..LEN in loop, one-shot or ping-pong mode on active-low pins.
module spram_led_sequencer #(
  parameter int          DEPTH_BITS = 4,
  parameter int          CHANNELS   = 3,
  parameter logic [31:0] DWELL      = 32'd12000000
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  WR_VALID,
  output logic                  WR_READY,
  input  logic [DEPTH_BITS-1:0] WR_ADDR,
  input  logic [CHANNELS-1:0]   WR_DATA,
  input  logic                  START,
  input  logic                  STOP,
  input  logic [1:0]            MODE,
  input  logic [DEPTH_BITS-1:0] LEN,
  output logic [CHANNELS-1:0]   LED_N,
  output logic                  BUSY,
  output logic                  DONE
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT1, S_WAIT2, S_HOLD, S_DONE} state_t;

  localparam logic [1:0]            MODE_ONESHOT  = 2'd1;
  localparam logic [1:0]            MODE_PINGPONG = 2'd2;
  localparam logic [DEPTH_BITS-1:0] IDX_ONE       = DEPTH_BITS'(1);

  state_t                state_reg, state_next;
  logic [DEPTH_BITS-1:0] index_reg, index_next;
  logic [DEPTH_BITS-1:0] len_reg, len_next;
  logic [DEPTH_BITS-1:0] step_index;
  logic                  dir_up_reg, dir_up_next, step_dir_up;
  logic [1:0]            mode_reg, mode_next;
  logic [31:0]           count_reg, count_next;
  logic [CHANNELS-1:0]   led_n_reg, led_n_next, pattern_n;

  logic                  wr_window;
  logic [13:0]           spram_addr;
  logic [15:0]           spram_din, spram_dout;
  logic                  spram_wren;
  logic                  unused_ok;

  // The host owns the RAM port only while nothing is playing.
  assign wr_window  = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign spram_addr = wr_window ? 14'(WR_ADDR) : 14'(index_reg);
  assign spram_din  = 16'(WR_DATA);
  assign spram_wren = wr_window && WR_VALID && !STOP;
  assign unused_ok  = &{1'b0, spram_dout};

  SB_SPRAM256KA u_spram (
    .ADDRESS   (spram_addr),
    .DATAIN    (spram_din),
    .MASKWREN  (4'b1111),
    .WREN      (spram_wren),
    .CHIPSELECT(1'b1),
    .CLOCK     (CLK),
    .STANDBY   (1'b0),
    .SLEEP     (1'b0),
    .POWEROFF  (1'b1),
    .DATAOUT   (spram_dout)
  );

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign pattern_n[gi] = ~spram_dout[gi];
    end
  endgenerate

  // Index that follows the current one; LEN=0 pins the index at 0 in every mode.
  always_comb begin
    step_index  = index_reg;
    step_dir_up = dir_up_reg;
    if (mode_reg == MODE_PINGPONG) begin
      if (len_reg == '0) begin
        step_index = '0;
      end else if (dir_up_reg) begin
        if (index_reg == len_reg) begin
          step_dir_up = 1'b0;
          step_index  = index_reg - IDX_ONE;
        end else begin
          step_index = index_reg + IDX_ONE;
        end
      end else begin
        if (index_reg == '0) begin
          step_dir_up = 1'b1;
          step_index  = IDX_ONE;
        end else begin
          step_index = index_reg - IDX_ONE;
        end
      end
    end else begin
      step_index = (index_reg == len_reg) ? '0 : index_reg + IDX_ONE;
    end
  end

  always_comb begin
    state_next  = state_reg;
    index_next  = index_reg;
    dir_up_next = dir_up_reg;
    mode_next   = mode_reg;
    len_next    = len_reg;
    count_next  = count_reg;
    led_n_next  = led_n_reg;
    if (STOP) begin
      state_next = S_IDLE;
      led_n_next = '1;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (START) begin
            index_next  = '0;
            dir_up_next = 1'b1;
            mode_next   = MODE;
            len_next    = LEN;
            state_next  = S_WAIT1;
          end
        end
        S_WAIT1: state_next = S_WAIT2;
        S_WAIT2: begin
          led_n_next = pattern_n;
          count_next = DWELL - 32'd1;
          state_next = S_HOLD;
        end
        S_HOLD: begin
          if (count_reg != '0) begin
            count_next = count_reg - 32'd1;
          end else if ((mode_reg == MODE_ONESHOT) && (index_reg == len_reg)) begin
            state_next = S_DONE;
          end else begin
            index_next  = step_index;
            dir_up_next = step_dir_up;
            state_next  = S_WAIT1;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_reg  <= S_IDLE;
      index_reg  <= '0;
      dir_up_reg <= 1'b1;
      mode_reg   <= '0;
      len_reg    <= '0;
      count_reg  <= '0;
      led_n_reg  <= '1;
    end else begin
      state_reg  <= state_next;
      index_reg  <= index_next;
      dir_up_reg <= dir_up_next;
      mode_reg   <= mode_next;
      len_reg    <= len_next;
      count_reg  <= count_next;
      led_n_reg  <= led_n_next;
    end
  end

  assign LED_N    = led_n_reg;
  assign BUSY     = (state_reg == S_WAIT1) || (state_reg == S_WAIT2) || (state_reg == S_HOLD);
  assign DONE     = (state_reg == S_DONE);
  assign WR_READY = wr_window;

endmodule

// File: tb/tb_spram_led_sequencer.sv
// Scoreboard bench: stimulus pushes cycle-stamped expected outputs derived from
// an index-sequence model; a negedge monitor pops and compares them.
module tb_spram_led_sequencer;

  localparam int DB   = 4;
  localparam int CH   = 3;
  localparam int DW   = 4;
  localparam int STEP = DW + 2;

  logic          CLK = 1'b0;
  logic          RESETN = 1'b0;
  logic          WR_VALID = 1'b0;
  logic          WR_READY;
  logic [DB-1:0] WR_ADDR = '0;
  logic [CH-1:0] WR_DATA = '0;
  logic          START = 1'b0;
  logic          STOP = 1'b0;
  logic [1:0]    MODE = '0;
  logic [DB-1:0] LEN = '0;
  logic [CH-1:0] LED_N;
  logic          BUSY;
  logic          DONE;

  spram_led_sequencer #(
    .DEPTH_BITS(DB),
    .CHANNELS  (CH),
    .DWELL     (32'(DW))
  ) dut (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .WR_VALID(WR_VALID),
    .WR_READY(WR_READY),
    .WR_ADDR (WR_ADDR),
    .WR_DATA (WR_DATA),
    .START   (START),
    .STOP    (STOP),
    .MODE    (MODE),
    .LEN     (LEN),
    .LED_N   (LED_N),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [CH-1:0] led;
    logic        busy;
    logic        done;
    logic        rdy;
    string       tag;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [CH-1:0] ref_mem [16];
  logic [CH-1:0] cur_led = '1;

  function automatic void push(input int t, input logic [CH-1:0] led, input logic busy,
                               input logic done, input logic rdy, input string tag);
    exp_t e;
    e.cyc = t; e.led = led; e.busy = busy; e.done = done; e.rdy = rdy; e.tag = tag;
    exp_q.push_back(e);
  endfunction

  // Entry shown at step k: loop walks 0..len cyclically, ping-pong bounces with period 2*len.
  function automatic int model_index(input int mode, input int len, input int k);
    int p;
    if (mode == 2 && len != 0) begin
      p = k % (2 * len);
      return (p <= len) ? p : 2 * len - p;
    end
    return k % (len + 1);
  endfunction

  always @(negedge CLK) begin : monitor
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (e.cyc != cyc || LED_N !== e.led || BUSY !== e.busy || DONE !== e.done || WR_READY !== e.rdy) begin
        errors++;
        $display("FAIL %s cyc=%0d: got led_n=%b busy=%b done=%b wr_ready=%b, expected led_n=%b busy=%b done=%b wr_ready=%b at cyc %0d",
                 e.tag, cyc, LED_N, BUSY, DONE, WR_READY, e.led, e.busy, e.done, e.rdy, e.cyc);
      end
    end
  end

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic write_entry(input int addr, input logic [CH-1:0] data);
    WR_VALID = 1'b1; WR_ADDR = DB'(addr); WR_DATA = data;
    ref_mem[addr] = data;
    $display("write addr=%0d data=%b at cyc %0d", addr, data, cyc);
    @(posedge CLK); #1;
    WR_VALID = 1'b0;
  endtask

  task automatic run_play(input logic [1:0] mode, input int len, input int nsteps,
                          input bit poke, input bit wr_with_start, input logic [CH-1:0] wr_val);
    int c, t, n, stop_at;
    logic [CH-1:0] led;
    c = cyc;
    if (wr_with_start) begin
      WR_VALID = 1'b1; WR_ADDR = '0; WR_DATA = wr_val;
      ref_mem[0] = wr_val;
    end
    START = 1'b1; MODE = mode; LEN = DB'(len);
    $display("play mode=%0d len=%0d steps=%0d poke=%0d wr=%0d at cyc %0d", mode, len, nsteps, poke, wr_with_start, c);
    push(c + 1, cur_led, 1'b1, 1'b0, 1'b0, "wait1_after_start");
    n = (mode == 2'd1) ? len + 1 : nsteps;
    led = cur_led;
    t = c + 3;
    for (int k = 0; k < n; k++) begin
      t = c + 3 + STEP * k;
      if (k > 0) push(t - 1, led, 1'b1, 1'b0, 1'b0, "pattern_held");
      led = ~ref_mem[model_index(int'(mode), len, k)];
      push(t, led, 1'b1, 1'b0, 1'b0, "pattern_new");
    end
    if (mode == 2'd1) begin
      push(t + DW - 1, led, 1'b1, 1'b0, 1'b0, "oneshot_last_hold");
      push(t + DW, led, 1'b0, 1'b1, 1'b1, "oneshot_done");
      stop_at = t + DW + 2;
    end else begin
      stop_at = t + DW;
    end
    @(posedge CLK); #1;
    START = 1'b0; WR_VALID = 1'b0;
    if (poke) begin
      // Lands on a HOLD edge of the first pattern: both must be ignored.
      wait_cyc(c + 4);
      START = 1'b1; MODE = 2'd1; LEN = '0;
      WR_VALID = 1'b1; WR_ADDR = DB'(1); WR_DATA = ~ref_mem[1];
      @(posedge CLK); #1;
      START = 1'b0; WR_VALID = 1'b0;
    end
    wait_cyc(stop_at);
    STOP = 1'b1;
    push(stop_at + 1, '1, 1'b0, 1'b0, 1'b1, "stop_to_idle");
    @(posedge CLK); #1;
    STOP = 1'b0;
    cur_led = '1;
  endtask

  initial begin
    int c;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (LED_N !== 3'b111 || BUSY !== 1'b0 || DONE !== 1'b0 || WR_READY !== 1'b1) begin
      errors++;
      $display("FAIL reset_held: got led_n=%b busy=%b done=%b wr_ready=%b, expected 111 0 0 1", LED_N, BUSY, DONE, WR_READY);
    end
    RESETN = 1'b1;
    push(cyc, 3'b111, 1'b0, 1'b0, 1'b1, "after_reset");
    @(posedge CLK); #1;

    write_entry(0, 3'd1);
    write_entry(1, 3'd2);
    write_entry(2, 3'd4);
    write_entry(3, 3'd7);
    for (int a = 4; a < 16; a++) write_entry(a, CH'($urandom_range(0, 7)));

    run_play(2'd0, 3, 9, 1'b1, 1'b0, '0);   // loop with ignored START/write in HOLD
    run_play(2'd1, 2, 0, 1'b0, 1'b0, '0);   // one-shot
    run_play(2'd2, 3, 8, 1'b0, 1'b0, '0);   // ping-pong, also reads entry 1 back
    run_play(2'd2, 0, 4, 1'b0, 1'b0, '0);   // ping-pong on a single entry
    run_play(2'd0, 1, 3, 1'b0, 1'b1, 3'd5); // write and start on the same edge
    run_play(2'd3, 2, 5, 1'b0, 1'b0, '0);   // mode 3 plays as loop

    // Asynchronous reset in the middle of HOLD.
    c = cyc;
    START = 1'b1; MODE = 2'd0; LEN = DB'(3);
    push(c + 1, cur_led, 1'b1, 1'b0, 1'b0, "wait1_before_async_reset");
    push(c + 3, ~ref_mem[0], 1'b1, 1'b0, 1'b0, "pattern_before_async_reset");
    @(posedge CLK); #1;
    START = 1'b0;
    wait_cyc(c + 4);
    RESETN = 1'b0;
    #1;
    checks++;
    if (LED_N !== 3'b111 || BUSY !== 1'b0 || DONE !== 1'b0 || WR_READY !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got led_n=%b busy=%b done=%b wr_ready=%b, expected 111 0 0 1", LED_N, BUSY, DONE, WR_READY);
    end
    @(posedge CLK); #1;
    RESETN = 1'b1;
    cur_led = '1;
    push(cyc, 3'b111, 1'b0, 1'b0, 1'b1, "idle_after_async_reset");
    @(posedge CLK); #1;

    for (int r = 0; r < 6; r++) begin
      for (int w = 0; w < 3; w++) write_entry($urandom_range(0, 15), CH'($urandom_range(0, 7)));
      run_play(2'($urandom_range(0, 3)), $urandom_range(0, 15), $urandom_range(2, 10), 1'b0, 1'b0, '0);
    end

    wait_cyc(cyc + 4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by cyc %0d, expected finish earlier", cyc);
    $fatal(1, "timeout");
  end

endmodule
